// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage and EX/MEM -> MEM/WB boundary register.
// Little-endian byte/halfword/word data-memory access with sign/zero-extended
// loads, debugger halt (i_step) and hazard flush (i_flush).
// Optional feature: define MEM_ALIGN_CHECK_EN to enable misaligned-access
// detection (store suppressed, write-back disabled, o_misaligned pulsed).
module memory_stage #(
    parameter int NBITS     = 32,
    parameter int REGS      = 5,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_step,
    input  logic                         i_flush,
    input  logic [NBITS-1:0]             i_alu_result,
    input  logic                         i_cero,
    input  logic [NBITS-1:0]             i_store_data,
    input  logic [REGS-1:0]              i_reg_dest,
    input  logic                         i_mem_read,
    input  logic                         i_mem_write,
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic                         i_branch,
    input  logic                         i_reg_write,
    input  logic                         i_mem_to_reg,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
    output logic [NBITS-1:0]             o_read_data,
    output logic [NBITS-1:0]             o_alu_result,
    output logic [REGS-1:0]              o_reg_dest,
    output logic                         o_reg_write,
    output logic                         o_mem_to_reg,
    output logic                         o_branch_taken,
    output logic [NBITS-1:0]             o_debug_data,
    output logic                         o_misaligned
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [NBITS-1:0] mem [MEM_DEPTH];

    logic [AW-1:0]    word_idx;
    logic [1:0]       lane_sel;
    logic [4:0]       lane_shift;
    logic [NBITS-1:0] wr_mask;
    logic [NBITS-1:0] wr_data;
    logic [NBITS-1:0] rd_shifted;
    logic [NBITS-1:0] load_ext;
    logic             misaligned;
    logic             store_en;
    logic             load_en;

    // Word index wraps modulo MEM_DEPTH; upper address bits are ignored.
    assign word_idx = i_alu_result[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=0; only memory accesses fault.
    always_comb begin
        misaligned = 1'b0;
        if (i_mem_read || i_mem_write) begin
            case (i_size)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = i_alu_result[0];
                default: misaligned = |i_alu_result[1:0];
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Lane selection, store byte-lane mask/data and extended load data.
    always_comb begin
        lane_sel   = 2'b00;
        wr_mask    = '1;
        wr_data    = i_store_data;
        load_ext   = '0;
        case (i_size)
            2'b00:   lane_sel = i_alu_result[1:0];
            2'b01:   lane_sel = {i_alu_result[1], 1'b0};
            default: lane_sel = 2'b00;
        endcase
        lane_shift = {lane_sel, 3'b000};
        rd_shifted = mem[word_idx] >> lane_shift;
        case (i_size)
            2'b00: begin
                wr_mask  = NBITS'(8'hFF) << lane_shift;
                wr_data  = NBITS'(i_store_data[7:0]) << lane_shift;
                load_ext = {{(NBITS-8){~i_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
            end
            2'b01: begin
                wr_mask  = NBITS'(16'hFFFF) << lane_shift;
                wr_data  = NBITS'(i_store_data[15:0]) << lane_shift;
                load_ext = {{(NBITS-16){~i_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
            end
            default: begin
                wr_mask  = '1;
                wr_data  = i_store_data;
                load_ext = rd_shifted;
            end
        endcase
    end

    // A simultaneous read+write is a store; reset, halt and flush all block writes.
    assign store_en = i_reset & i_step & ~i_flush & i_mem_write & ~misaligned;
    assign load_en  = i_mem_read & ~i_mem_write & ~misaligned;

    // Byte-lane merge into the addressed word; memory is never cleared.
    always_ff @(posedge i_clk) begin
        if (store_en) begin
            mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Pipeline boundary register: reset > halt > flush > normal.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_read_data    <= '0;
            o_alu_result   <= '0;
            o_reg_dest     <= '0;
            o_reg_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_branch_taken <= 1'b0;
        end else if (i_step) begin
            if (i_flush) begin
                o_read_data    <= '0;
                o_alu_result   <= '0;
                o_reg_dest     <= '0;
                o_reg_write    <= 1'b0;
                o_mem_to_reg   <= 1'b0;
                o_branch_taken <= 1'b0;
            end else begin
                o_read_data    <= load_en ? load_ext : '0;
                o_alu_result   <= i_alu_result;
                o_reg_dest     <= i_reg_dest;
                o_reg_write    <= i_reg_write & ~misaligned;
                o_mem_to_reg   <= i_mem_to_reg;
                o_branch_taken <= i_branch & i_cero;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle fault flag, frozen by halt and cleared by flush like other outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_misaligned <= 1'b0;
        end else if (i_step) begin
            o_misaligned <= ~i_flush & misaligned;
        end
    end
`else
    assign o_misaligned = 1'b0;
`endif

    // Debug read port keeps running while the pipeline is halted.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_debug_data <= '0;
        end else begin
            o_debug_data <= mem[i_debug_addr];
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic        flush;
    logic [31:0] alu_result;
    logic        cero;
    logic [31:0] store_data;
    logic [4:0]  reg_dest;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        uns;
    logic        branch;
    logic        reg_write;
    logic        mem_to_reg;
    logic [7:0]  debug_addr;
    logic [31:0] read_data;
    logic [31:0] alu_q;
    logic [4:0]  dest_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic        branch_taken;
    logic [31:0] debug_data;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    memory_stage #(.NBITS(32), .REGS(5), .MEM_DEPTH(256)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_step         (step),
        .i_flush        (flush),
        .i_alu_result   (alu_result),
        .i_cero         (cero),
        .i_store_data   (store_data),
        .i_reg_dest     (reg_dest),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_size         (size),
        .i_unsigned     (uns),
        .i_branch       (branch),
        .i_reg_write    (reg_write),
        .i_mem_to_reg   (mem_to_reg),
        .i_debug_addr   (debug_addr),
        .o_read_data    (read_data),
        .o_alu_result   (alu_q),
        .o_reg_dest     (dest_q),
        .o_reg_write    (reg_write_q),
        .o_mem_to_reg   (mem_to_reg_q),
        .o_branch_taken (branch_taken),
        .o_debug_data   (debug_data),
        .o_misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; step = 1'b1; flush = 1'b0; alu_result = '0; cero = 1'b0;
        store_data = '0; reg_dest = '0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b11; uns = 1'b0; branch = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        idle();
        alu_result = addr; store_data = data; size = sz; mem_write = 1'b1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic u, input logic [4:0] rd);
        idle();
        alu_result = addr; size = sz; uns = u; mem_read = 1'b1;
        reg_write = 1'b1; mem_to_reg = 1'b1; reg_dest = rd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},  read_data, 32'h0);
        check({tag, "_alu"}, alu_q, 32'h0);
        check({tag, "_dst"}, {27'h0, dest_q}, 32'h0);
        check({tag, "_ctl"}, {28'h0, reg_write_q, mem_to_reg_q, branch_taken, misaligned}, 32'h0);
        check({tag, "_dbg"}, debug_data, 32'h0);
    endtask

    initial begin
        idle();
        debug_addr = '0;

        // Reset with random inputs.
        rst_n = 1'b0; alu_result = $urandom; store_data = $urandom; reg_dest = 5'h1F;
        reg_write = 1'b1; mem_to_reg = 1'b1; branch = 1'b1; cero = 1'b1; mem_read = 1'b1;
        tick(); tick();
        check_all_zero("reset0");

        // Reset drops a pending store and leaves memory intact.
        store(32'h0, 32'h11223344, 2'b11);
        tick();
        rst_n = 1'b0; alu_result = 32'h0; store_data = $urandom; mem_write = 1'b1;
        reg_write = 1'b1; reg_dest = 5'd9; branch = 1'b1; cero = 1'b1;
        tick(); tick();
        check_all_zero("reset1");
        idle(); debug_addr = 8'd0;
        tick();
        check("reset_mem_kept", debug_data, 32'h11223344);

        // Word store then signed/unsigned byte loads.
        store(32'h10, 32'hDEADBEEF, 2'b11);
        tick();
        check("store_rd_zero", read_data, 32'h0);
        check("store_alu", alu_q, 32'h10);
        load(32'h11, 2'b00, 1'b0, 5'd7);
        tick();
        check("lb_signed", read_data, 32'hFFFFFFBE);
        check("lb_alu", alu_q, 32'h11);
        check("lb_dest", {27'h0, dest_q}, 32'd7);
        check("lb_ctl", {30'h0, reg_write_q, mem_to_reg_q}, 32'h3);
        load(32'h11, 2'b00, 1'b1, 5'd7);
        tick();
        check("lbu", read_data, 32'h000000BE);

        // Halfword store merges into upper lanes.
        store(32'h10, 32'hAAAAAAAA, 2'b11);
        tick();
        store(32'h12, 32'h00001234, 2'b01);
        tick();
        load(32'h12, 2'b01, 1'b0, 5'd3);
        tick();
        check("lh_signed", read_data, 32'h00001234);
        load(32'h10, 2'b11, 1'b0, 5'd3);
        tick();
        check("lw_merged", read_data, 32'h1234AAAA);
        load(32'h10, 2'b01, 1'b0, 5'd3);
        tick();
        check("lh_neg", read_data, 32'hFFFFAAAA);
        load(32'h10, 2'b01, 1'b1, 5'd3);
        tick();
        check("lhu", read_data, 32'h0000AAAA);
        load(32'h410, 2'b11, 1'b0, 5'd3);
        tick();
        check("lw_wrap", read_data, 32'h1234AAAA);

        // Halt blocks the store and freezes outputs; debug keeps running.
        store(32'h20, 32'h0, 2'b11);
        tick();
        load(32'h10, 2'b11, 1'b0, 5'd4);
        tick();
        store(32'h20, 32'h00000055, 2'b00);
        step = 1'b0; debug_addr = 8'd8;
        tick(); tick();
        check("halt_mem", debug_data, 32'h0);
        check("halt_rd", read_data, 32'h1234AAAA);
        check("halt_alu", alu_q, 32'h10);
        check("halt_dest", {27'h0, dest_q}, 32'd4);
        step = 1'b1;
        tick();
        check("resume_alu", alu_q, 32'h20);
        check("resume_rd", read_data, 32'h0);
        idle();
        tick();
        check("resume_mem", debug_data, 32'h00000055);

        // Flush inserts a bubble and suppresses the store.
        store(32'h30, 32'h0, 2'b11);
        tick();
        store(32'h30, 32'h1, 2'b11);
        flush = 1'b1; reg_write = 1'b1; reg_dest = 5'd5; branch = 1'b1; cero = 1'b1;
        debug_addr = 8'd12;
        tick();
        check("flush_rw", {31'h0, reg_write_q}, 32'h0);
        check("flush_alu", alu_q, 32'h0);
        check("flush_br", {31'h0, branch_taken}, 32'h0);
        idle();
        tick();
        check("flush_mem", debug_data, 32'h0);
        idle(); branch = 1'b1; cero = 1'b1;
        tick();
        check("br_taken", {31'h0, branch_taken}, 32'h1);
        idle(); branch = 1'b1; cero = 1'b0;
        tick();
        check("br_not_taken", {31'h0, branch_taken}, 32'h0);

        // Read+write together is a store with zero read data.
        store(32'h44, 32'h00000077, 2'b11);
        mem_read = 1'b1;
        tick();
        check("rw_rd_zero", read_data, 32'h0);
        load(32'h44, 2'b11, 1'b0, 5'd1);
        tick();
        check("rw_stored", read_data, 32'h00000077);

        // Misaligned word store at 0x41.
        store(32'h40, 32'h0, 2'b11);
        tick();
        store(32'h41, 32'hCAFEF00D, 2'b11);
        reg_write = 1'b1;
        debug_addr = 8'd16;
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_flag", {31'h0, misaligned}, 32'h1);
        check("mis_rw", {31'h0, reg_write_q}, 32'h0);
        idle();
        tick();
        check("mis_clear", {31'h0, misaligned}, 32'h0);
        check("mis_mem", debug_data, 32'h0);
`else
        check("mis_flag", {31'h0, misaligned}, 32'h0);
        check("mis_rw", {31'h0, reg_write_q}, 32'h1);
        idle();
        tick();
        check("mis_mem", debug_data, 32'hCAFEF00D);
        // Byte store into lane 3 and signed reload.
        store(32'h43, 32'h000000A5, 2'b00);
        tick();
        load(32'h43, 2'b00, 1'b0, 5'd2);
        tick();
        check("lb_lane3", read_data, 32'hFFFFFFA5);
        idle();
        tick();
        check("lane3_mem", debug_data, 32'hA5FEF00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
